delay_timer: RTL and testbench

Parametrised, runtime-programmable delay timer for the HD44780 controller sequencing (power-on waits, enable pulse widths, instruction execution delays).
- A fixed clock prescaler generates a time-base tick.
- A loadable down-counter counts a caller-supplied number of ticks.
- Supports one-shot and auto-reload (periodic) modes, start/abort control, and busy/done status.
- Replaces fixed-count instances; one timer serves all delays, selected at start time.

---
 rtl/delay_timer_if.sv | 22 ++
 rtl/delay_timer.sv | 100 ++++++++++
 tb/tb_delay_timer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/delay_timer_if.sv
// rtl/delay_timer_if.sv - control/status bundle between a sequencer and delay_timer
interface delay_timer_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic [CNT_WIDTH-1:0] period;
    logic                 periodic;
    logic                 abort;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] remaining;

    modport master (
        output start, period, periodic, abort,
        input  busy, done, remaining
    );

    modport slave (
        input  start, period, periodic, abort,
        output busy, done, remaining
    );
endinterface

// File: rtl/delay_timer.sv
// rtl/delay_timer.sv - prescaled, programmable one-shot/periodic delay timer
module delay_timer #(
    parameter int CNT_WIDTH = 16,
    parameter int PRESCALE  = 50
) (
    input  logic          clk,
    input  logic          rst,
    delay_timer_if.slave  tmr
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]        PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0]        PRE_ONE  = PW'(1);
    localparam logic [CNT_WIDTH-1:0] REM_ONE  = CNT_WIDTH'(1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        pre_q;
    logic [CNT_WIDTH-1:0] rem_q;
    logic [CNT_WIDTH-1:0] period_q;
    logic                 periodic_q;
    logic                 done_q;
    logic                 tick;
    logic                 launch;

    assign tick   = (state_q == RUN) && (pre_q == PRE_LAST);
    assign launch = (state_q == IDLE) && !tmr.abort && tmr.start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (launch && (tmr.period != '0)) state_d = RUN;
            RUN: begin
                if (tmr.abort)
                    state_d = IDLE;
                else if (tick && (rem_q == REM_ONE) && !periodic_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Abort wins over a coincident final tick, so it suppresses done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q      <= '0;
            rem_q      <= '0;
            period_q   <= '0;
            periodic_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    pre_q <= '0;
                    if (launch) begin
                        if (tmr.period != '0) begin
                            period_q   <= tmr.period;
                            periodic_q <= tmr.periodic;
                            rem_q      <= tmr.period;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (tmr.abort) begin
                        pre_q <= '0;
                        rem_q <= '0;
                    end else begin
                        pre_q <= tick ? '0 : pre_q + PRE_ONE;
                        if (tick) begin
                            if (rem_q != REM_ONE) begin
                                rem_q <= rem_q - REM_ONE;
                            end else begin
                                done_q <= 1'b1;
                                rem_q  <= periodic_q ? period_q : '0;
                            end
                        end
                    end
                end
                default: begin
                    pre_q <= '0;
                    rem_q <= '0;
                end
            endcase
        end
    end

    always_comb begin
        tmr.busy      = (state_q == RUN);
        tmr.done      = done_q;
        tmr.remaining = rem_q;
    end
endmodule

// File: tb/tb_delay_timer.sv
// tb/tb_delay_timer.sv - directed self-checking bench for delay_timer
module tb_delay_timer;
    logic clk;
    logic rst;
    int   total;
    int   fails;

    delay_timer_if #(.CNT_WIDTH(16)) t4 ();
    delay_timer_if #(.CNT_WIDTH(16)) t1 ();

    delay_timer #(.CNT_WIDTH(16), .PRESCALE(4)) dut4 (.clk(clk), .rst(rst), .tmr(t4.slave));
    delay_timer #(.CNT_WIDTH(16), .PRESCALE(1)) dut1 (.clk(clk), .rst(rst), .tmr(t1.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic b, input logic d, input logic [15:0] r);
        chk({tag, ".busy"}, {31'd0, t4.busy}, {31'd0, b});
        chk({tag, ".done"}, {31'd0, t4.done}, {31'd0, d});
        chk({tag, ".rem"}, {16'd0, t4.remaining}, {16'd0, r});
    endtask

    initial begin
        int cnt;
        total = 0;
        fails = 0;
        rst = 1'b0;
        t4.start = 1'b0; t4.period = '0; t4.periodic = 1'b0; t4.abort = 1'b0;
        t1.start = 1'b0; t1.period = '0; t1.periodic = 1'b0; t1.abort = 1'b0;
        #2;
        chk4("reset", 1'b0, 1'b0, 16'd0);
        step(); step();
        rst = 1'b1;
        step();
        chk4("idle_after_reset", 1'b0, 1'b0, 16'd0);

        // 1: one-shot, period 3
        t4.start = 1'b1; t4.period = 16'd3; t4.periodic = 1'b0;
        step();
        t4.start = 1'b0;
        chk4("t1_e0", 1'b1, 1'b0, 16'd3);
        for (int e = 1; e <= 13; e++) begin
            step();
            chk4($sformatf("t1_e%0d", e), e < 12, e == 12, (e < 12) ? 16'(3 - e / 4) : 16'd0);
        end

        // 2: zero period
        t4.start = 1'b1; t4.period = 16'd0;
        step();
        t4.start = 1'b0;
        chk4("t2_e0", 1'b0, 1'b1, 16'd0);
        step();
        chk4("t2_e1", 1'b0, 1'b0, 16'd0);

        // 3: periodic, period 2, abort sampled at edge 18
        t4.start = 1'b1; t4.period = 16'd2; t4.periodic = 1'b1;
        step();
        t4.start = 1'b0; t4.periodic = 1'b0;
        chk4("t3_e0", 1'b1, 1'b0, 16'd2);
        for (int e = 1; e <= 30; e++) begin
            step();
            if (e == 17) t4.abort = 1'b1;
            if (e == 18) t4.abort = 1'b0;
            chk4($sformatf("t3_e%0d", e), e < 18, (e == 8) || (e == 16),
                 (e < 18) ? (((e / 4) % 2 == 0) ? 16'd2 : 16'd1) : 16'd0);
        end

        // 4: abort coinciding with the final tick
        t4.start = 1'b1; t4.period = 16'd1;
        step();
        t4.start = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 3) t4.abort = 1'b1;
            if (e == 4) t4.abort = 1'b0;
            chk4($sformatf("t4_e%0d", e), e < 4, 1'b0, (e < 4) ? 16'd1 : 16'd0);
        end

        // 5: start/period/mode ignored while running, back-to-back restart
        t4.start = 1'b1; t4.period = 16'd5; t4.periodic = 1'b0;
        step();
        for (int e = 1; e <= 20; e++) begin
            t4.start = 1'b1; t4.period = 16'd2; t4.periodic = e[0];
            step();
            if (e < 20) chk4($sformatf("t5_e%0d", e), 1'b1, 1'b0, 16'(5 - e / 4));
        end
        chk4("t5_e20", 1'b0, 1'b1, 16'd0);
        t4.start = 1'b1; t4.period = 16'd2; t4.periodic = 1'b0;
        step();
        t4.start = 1'b0;
        chk4("t5_restart", 1'b1, 1'b0, 16'd2);
        for (int e = 1; e <= 8; e++) step();
        chk4("t5_second_done", 1'b0, 1'b1, 16'd0);

        // 6: asynchronous reset mid-run
        t4.start = 1'b1; t4.period = 16'd5;
        step();
        t4.start = 1'b0;
        step(); step();
        chk4("t6_running", 1'b1, 1'b0, 16'd5);
        #2;
        rst = 1'b0;
        #1;
        chk4("t6_async_reset", 1'b0, 1'b0, 16'd0);
        step();
        rst = 1'b1;
        step(); step(); step();
        chk4("t6_idle_after_release", 1'b0, 1'b0, 16'd0);

        // 6b: PRESCALE=1, full-scale period
        t1.start = 1'b1; t1.period = 16'hFFFF; t1.periodic = 1'b0;
        step();
        t1.start = 1'b0;
        chk("t6b_busy", {31'd0, t1.busy}, 32'd1);
        cnt = 0;
        do begin
            step();
            cnt++;
            if (cnt == 1) chk("t6b_rem_e1", {16'd0, t1.remaining}, 32'h0000FFFE);
        end while (!t1.done && cnt < 70000);
        chk("t6b_done_cycle", cnt, 32'd65535);
        chk("t6b_busy_end", {31'd0, t1.busy}, 32'd0);
        step();
        chk("t6b_done_pulse", {31'd0, t1.done}, 32'd0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
